pavana_ooo_mem_slave: RTL and testbench

- Out-of-order memory slave endpoint. Connects directly to one slave_N port of the 4x4 pavana OoO crossbar.
- Accepts req/addr/cmd/reqtid/wdata requests and stores data in an internal word RAM.
- Returns read responses tagged with resptid. Each read gets an address-dependent latency, so responses come back out of order.
- Used as the downstream load for crossbar synthesis and simulation benches.

---
 rtl/pavana_ooo_mem_slave_if.sv | 24 ++
 rtl/pavana_ooo_mem_slave.sv | 111 +++++++++++
 tb/tb_pavana_ooo_mem_slave.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pavana_ooo_mem_slave_if.sv
// Request/response bundle between one crossbar slave port and a memory slave endpoint.
interface pavana_ooo_mem_slave_if #(
  parameter int TID_W = 2
);
  logic             req;
  logic [31:0]      addr;
  logic             cmd;
  logic [TID_W-1:0] reqtid;
  logic [31:0]      wdata;
  logic             ack;
  logic [TID_W-1:0] resptid;
  logic [31:0]      rdata;
  logic             resp;

  modport master (
    output req, addr, cmd, reqtid, wdata,
    input  ack, resptid, rdata, resp
  );

  modport slave (
    input  req, addr, cmd, reqtid, wdata,
    output ack, resptid, rdata, resp
  );
endinterface

// File: rtl/pavana_ooo_mem_slave.sv
// Out-of-order memory slave: word RAM plus a pending-read buffer whose latency depends on addr[5:4].
// Define PAVANA_SLAVE_WRRESP_EN to make writes also take a buffer entry and return a zero-data response.
module pavana_ooo_mem_slave #(
  parameter int AW          = 8,
  parameter int BUF_ENTRIES = 4,
  parameter int LAT_MIN     = 1,
  parameter int TID_W       = 2
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pavana_ooo_mem_slave_if.slave bus
);
  localparam int IW = (BUF_ENTRIES > 1) ? $clog2(BUF_ENTRIES) : 1;

  logic [31:0]            mem_q [2**AW];
  logic [BUF_ENTRIES-1:0] vld_q, vld_d;
  logic [TID_W-1:0]       tid_q [BUF_ENTRIES];
  logic [TID_W-1:0]       tid_d [BUF_ENTRIES];
  logic [31:0]            dat_q [BUF_ENTRIES];
  logic [31:0]            dat_d [BUF_ENTRIES];
  logic [3:0]             cnt_q [BUF_ENTRIES];
  logic [3:0]             cnt_d [BUF_ENTRIES];
  logic                   resp_q, resp_d;
  logic [TID_W-1:0]       resptid_q, resptid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [AW-1:0] widx;
  logic          free_any, sel_any, alloc;
  logic [IW-1:0] free_idx, sel_idx;
  logic          unused_addr;

  assign widx        = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // Both encoders look at pre-edge state, so a slot freed this cycle is never reused this cycle.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    sel_any  = 1'b0;
    sel_idx  = '0;
    for (int i = BUF_ENTRIES - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (vld_q[i] && (cnt_q[i] == 4'd0)) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

`ifdef PAVANA_SLAVE_WRRESP_EN
  assign bus.ack = bus.req && free_any;
  assign alloc   = bus.req && free_any;
`else
  assign bus.ack = bus.req && (bus.cmd || free_any);
  assign alloc   = bus.req && !bus.cmd && free_any;
`endif

  always_comb begin
    vld_d = vld_q;
    tid_d = tid_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    for (int i = 0; i < BUF_ENTRIES; i++) begin
      if (vld_q[i] && (cnt_q[i] != 4'd0)) cnt_d[i] = cnt_q[i] - 4'd1;
    end
    if (sel_any) vld_d[sel_idx] = 1'b0;
    if (alloc) begin
      vld_d[free_idx] = 1'b1;
      tid_d[free_idx] = bus.reqtid;
      dat_d[free_idx] = bus.cmd ? 32'h0 : mem_q[widx];
      cnt_d[free_idx] = bus.cmd ? 4'(LAT_MIN) : 4'(LAT_MIN) + {2'b00, bus.addr[5:4]};
    end
    resp_d    = sel_any;
    resptid_d = sel_any ? tid_q[sel_idx] : resptid_q;
    rdata_d   = sel_any ? dat_q[sel_idx] : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q     <= '0;
      resp_q    <= 1'b0;
      resptid_q <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < BUF_ENTRIES; i++) begin
        tid_q[i] <= '0;
        dat_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      tid_q     <= tid_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      resptid_q <= resptid_d;
      rdata_q   <= rdata_d;
    end
  end

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (bus.ack && bus.cmd) mem_q[widx] <= bus.wdata;
  end

  assign bus.resp    = resp_q;
  assign bus.resptid = resptid_q;
  assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_pavana_ooo_mem_slave.sv
// Bench for pavana_ooo_mem_slave: directed vector table, hand sequences and a timestamp-based reference model.
module tb_pavana_ooo_mem_slave;
  localparam int NB   = 4;
  localparam int LATM = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pavana_ooo_mem_slave_if #(.TID_W(2)) bus ();

  pavana_ooo_mem_slave #(.AW(8), .BUF_ENTRIES(NB), .LAT_MIN(LATM), .TID_W(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model: each pending entry carries the cycle from which it may be returned.
  bit          m_vld [NB];
  logic [1:0]  m_tid [NB];
  logic [31:0] m_dat [NB];
  int          m_rdy [NB];
  logic [31:0] m_mem [256];
  logic        m_resp;
  logic [1:0]  m_rtid;
  logic [31:0] m_rdat;

  typedef struct {
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [1:0]  tid;
    logic [31:0] wdata;
    logic        e_ack;
    logic        e_resp;
    logic [1:0]  e_tid;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic r, input logic c, input logic [31:0] a, input logic [1:0] t,
                              input logic [31:0] d, input logic er, input logic [1:0] et,
                              input logic [31:0] ed);
    vec_t v;
    v.req = r; v.cmd = c; v.addr = a; v.tid = t; v.wdata = d;
    v.e_ack = r; v.e_resp = er; v.e_tid = et; v.e_rdata = ed;
    return v;
  endfunction

  function automatic logic [31:0] fillv(input int w);
    return 32'hC0DE_0000 | 32'(w * 273 + 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m_vld[i] = 1'b0;
    m_resp = 1'b0;
    m_rtid = 2'd0;
    m_rdat = 32'd0;
  endtask

  // One clock cycle: drive, check ack mid-cycle, advance model, check registered outputs after the edge.
  task automatic cyc(input logic r, input logic c, input logic [31:0] a, input logic [1:0] t,
                     input logic [31:0] d, output logic acked);
    int fs;
    int ss;
    logic e_ack;
    int w;
    bus.req = r; bus.cmd = c; bus.addr = a; bus.reqtid = t; bus.wdata = d;
    #4;
    fs = -1;
    for (int i = NB - 1; i >= 0; i--) if (!m_vld[i]) fs = i;
`ifdef PAVANA_SLAVE_WRRESP_EN
    e_ack = r && (fs >= 0);
`else
    e_ack = r && (c || (fs >= 0));
`endif
    acked = bus.ack;
    if (r) check("ack", 32'(bus.ack), 32'(e_ack));
    ss = -1;
    for (int i = NB - 1; i >= 0; i--) if (m_vld[i] && (m_rdy[i] <= cyc_n)) ss = i;
    if (ss >= 0) begin
      m_resp = 1'b1; m_rtid = m_tid[ss]; m_rdat = m_dat[ss]; m_vld[ss] = 1'b0;
    end else begin
      m_resp = 1'b0;
    end
    if (e_ack) begin
      w = int'(a[9:2]);
      if (c) begin
        m_mem[w] = d;
`ifdef PAVANA_SLAVE_WRRESP_EN
        m_vld[fs] = 1'b1; m_tid[fs] = t; m_dat[fs] = 32'h0; m_rdy[fs] = cyc_n + 1 + LATM;
`endif
      end else begin
        m_vld[fs] = 1'b1; m_tid[fs] = t; m_dat[fs] = m_mem[w];
        m_rdy[fs] = cyc_n + 1 + LATM + int'(a[5:4]);
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    check("resp", 32'(bus.resp), 32'(m_resp));
    check("resptid", 32'(bus.resptid), 32'(m_rtid));
    check("rdata", bus.rdata, m_rdat);
  endtask

  task automatic idle(input int n);
    logic ak;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 2'd0, 32'h0, ak);
  endtask

  task automatic req_hold(input logic c, input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    logic ak;
    ak = 1'b0;
    for (int k = 0; k < 40 && !ak; k++) cyc(1'b1, c, a, t, d, ak);
    if (!ak) begin
      n_chk++; n_err++;
      $display("FAIL req_hold_timeout cycle %0d: got ack 0 expected ack within 40 cycles", cyc_n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ak;
    logic pr, pc;
    logic [31:0] pa, pd;
    logic [1:0] pt;
    bit hold;
    int stale;

    bus.req = 1'b0; bus.cmd = 1'b0; bus.addr = 32'h0; bus.reqtid = 2'd0; bus.wdata = 32'h0;
    model_clear();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp", 32'(bus.resp), 32'd0);
    check("reset_resptid", 32'(bus.resptid), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) req_hold(1'b1, 32'(w) << 2, 2'(w), fillv(w));
    idle(8);

    // Vector table: write-then-read, out-of-order return, two entries eligible in the same cycle.
    vt[0]  = mk(1, 1, 32'h10, 2'd1, 32'hDEAD_BEEF, 0, 2'd0, 32'h0);
    vt[1]  = mk(1, 0, 32'h10, 2'd2, 32'h0, 0, 2'd0, 32'h0);
`ifdef PAVANA_SLAVE_WRRESP_EN
    vt[2]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'd1, 32'h0);
`else
    vt[2]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
`endif
    vt[3]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    vt[4]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'd2, 32'hDEAD_BEEF);
    vt[5]  = mk(1, 0, 32'h30, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    vt[6]  = mk(1, 0, 32'h00, 2'd3, 32'h0, 0, 2'd0, 32'h0);
    vt[7]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    vt[8]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'd3, fillv(0));
    vt[9]  = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    vt[10] = mk(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'd0, fillv(12));
    vt[11] = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    vt[12] = mk(1, 0, 32'h14, 2'd1, 32'h0, 0, 2'd0, 32'h0);
    vt[13] = mk(1, 0, 32'h08, 2'd2, 32'h0, 0, 2'd0, 32'h0);
    vt[14] = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);
    vt[15] = mk(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'd1, fillv(5));
    vt[16] = mk(0, 0, 32'h0, 2'd0, 32'h0, 1, 2'd2, fillv(2));
    vt[17] = mk(0, 0, 32'h0, 2'd0, 32'h0, 0, 2'd0, 32'h0);

    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].req, vt[i].cmd, vt[i].addr, vt[i].tid, vt[i].wdata, ak);
      if (vt[i].req) check($sformatf("tbl%0d_ack", i), 32'(ak), 32'(vt[i].e_ack));
      check($sformatf("tbl%0d_resp", i), 32'(bus.resp), 32'(vt[i].e_resp));
      if (vt[i].e_resp) begin
        check($sformatf("tbl%0d_tid", i), 32'(bus.resptid), 32'(vt[i].e_tid));
        check($sformatf("tbl%0d_rdata", i), bus.rdata, vt[i].e_rdata);
      end
    end
    idle(8);

    // Full buffer: four L=4 reads fill it, fifth read waits until the first response edge.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h30, 2'(i), 32'h0, ak);
      check($sformatf("full_ack%0d", i), 32'(ak), 32'd1);
    end
    cyc(1'b1, 1'b0, 32'h30, 2'd0, 32'h0, ak);
    check("full_rd_blocked", 32'(ak), 32'd0);
    cyc(1'b1, 1'b1, 32'h3C, 2'd1, fillv(15), ak);
`ifdef PAVANA_SLAVE_WRRESP_EN
    check("full_wr_ack", 32'(ak), 32'd0);
`else
    check("full_wr_ack", 32'(ak), 32'd1);
`endif
    cyc(1'b1, 1'b0, 32'h30, 2'd0, 32'h0, ak);
    check("full_rd_freed", 32'(ak), 32'd1);
    idle(16);

`ifdef PAVANA_SLAVE_WRRESP_EN
    cyc(1'b1, 1'b1, 32'h04, 2'd2, 32'h1234_5678, ak);
    check("wrresp_ack", 32'(ak), 32'd1);
    idle(1);
    check("wrresp_early", 32'(bus.resp), 32'd0);
    idle(1);
    check("wrresp_resp", 32'(bus.resp), 32'd1);
    check("wrresp_tid", 32'(bus.resptid), 32'd2);
    check("wrresp_rdata", bus.rdata, 32'd0);
    cyc(1'b1, 1'b0, 32'h04, 2'd1, 32'h0, ak);
    idle(2);
    check("wrresp_rd_resp", 32'(bus.resp), 32'd1);
    check("wrresp_rd_rdata", bus.rdata, 32'h1234_5678);
    idle(6);
`endif

    // Randomized traffic; a refused request is held until accepted.
    hold = 1'b0;
    pr = 1'b0; pc = 1'b0; pa = 32'h0; pd = 32'h0; pt = 2'd0;
    for (int k = 0; k < 1500; k++) begin
      if (!hold) begin
        pr = ($urandom_range(0, 99) < 60);
        pc = ($urandom_range(0, 99) < 30);
        pa = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
        pt = 2'($urandom);
        pd = $urandom;
      end
      cyc(pr, pc, pa, pt, pd, ak);
      hold = pr && !ak;
    end
    idle(16);

    // Reset with two reads pending: they must never come back.
    cyc(1'b1, 1'b0, 32'h30, 2'd1, 32'h0, ak);
    cyc(1'b1, 1'b0, 32'h34, 2'd2, 32'h0, ak);
    bus.req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_resp", 32'(bus.resp), 32'd0);
    check("midrst_resptid", 32'(bus.resptid), 32'd0);
    check("midrst_rdata", bus.rdata, 32'd0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 2'd0, 32'h0, ak);
      if (bus.resp) stale++;
    end
    check("post_rst_stale", 32'(stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
